// File: rtl/seg_frame_capture.sv
// seg_frame_capture: seven-segment bus receiver.
// Rebuilds time/money fields from the scanned digit stream.
module seg_frame_capture #(
   parameter int SEG_LAG      = 1,
   parameter int IDLE_TIMEOUT = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] dig_pos,
   input  logic [6:0] dig_sec,
   output logic [6:0] seltime,
   output logic [6:0] selmoney,
   output logic       valid,
   output logic       frame_err,
   output logic       active
);

   typedef enum logic [2:0] {
      SYNC,
      D0,
      D1,
      D2,
      D3
   } state_t;

   localparam logic [7:0] TMO = 8'(IDLE_TIMEOUT);

   state_t     state;
   state_t     state_n;
   logic [3:0] pos_d;
   logic [3:0] exp_pos;
   logic [4:0] dec;
   logic [3:0] tt_q;
   logic [3:0] to_q;
   logic [3:0] mt_q;
   logic       ld_tt;
   logic       ld_to;
   logic       ld_mt;
   logic       done;
   logic       valid_n;
   logic       err_n;
   logic [7:0] cnt_q;
   logic [7:0] cnt_n;
   logic       idle;
   logic       tmo;
   logic       active_n;

   // {ok, digit}; anything but an exact glyph is rejected
   function automatic logic [4:0] seg_dec(input logic [6:0] s);
      case (s)
         7'h3F:   seg_dec = {1'b1, 4'd0};
         7'h06:   seg_dec = {1'b1, 4'd1};
         7'h5B:   seg_dec = {1'b1, 4'd2};
         7'h4F:   seg_dec = {1'b1, 4'd3};
         7'h66:   seg_dec = {1'b1, 4'd4};
         7'h6D:   seg_dec = {1'b1, 4'd5};
         7'h7D:   seg_dec = {1'b1, 4'd6};
         7'h07:   seg_dec = {1'b1, 4'd7};
         7'h7F:   seg_dec = {1'b1, 4'd8};
         7'h67:   seg_dec = {1'b1, 4'd9};
         default: seg_dec = 5'd0;
      endcase
   endfunction

   assign dec = seg_dec(dig_sec);

   if (SEG_LAG == 0) begin : g_nolag
      assign pos_d = dig_pos;
   end else begin : g_lag
      logic [3:0] pos_q;
      // delay the strobe so it lines up with its pattern
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) pos_q <= '0;
         else        pos_q <= dig_pos;
      end
      assign pos_d = pos_q;
   end

   // idle counter, activity flag and the timeout event
   always_comb begin
      idle     = (dig_pos == 4'd0);
      cnt_n    = '0;
      if (idle)
         cnt_n = (cnt_q == TMO) ? cnt_q : cnt_q + 8'd1;
      tmo      = idle && (cnt_n == TMO);
      active_n = active;
      if (!idle)    active_n = 1'b1;
      else if (tmo) active_n = 1'b0;
   end

   // frame tracker: next state, digit loads, strobes
   always_comb begin
      state_n = state;
      valid_n = 1'b0;
      err_n   = 1'b0;
      ld_tt   = 1'b0;
      ld_to   = 1'b0;
      ld_mt   = 1'b0;
      done    = 1'b0;
      exp_pos = 4'b0001;
      case (state)
         D1:      exp_pos = 4'b0010;
         D2:      exp_pos = 4'b0100;
         D3:      exp_pos = 4'b1000;
         default: exp_pos = 4'b0001;
      endcase
      if (pos_d == exp_pos) begin
         if (dec[4]) begin
            case (state)
               D1: begin
                  ld_to   = 1'b1;
                  state_n = D2;
               end
               D2: begin
                  ld_mt   = 1'b1;
                  state_n = D3;
               end
               D3: begin
                  done    = 1'b1;
                  valid_n = 1'b1;
                  state_n = D0;
               end
               default: begin
                  ld_tt   = 1'b1;
                  state_n = D1;
               end
            endcase
         end else begin
            err_n   = 1'b1;
            state_n = SYNC;
         end
      end else if (pos_d == 4'd0) begin
         state_n = SYNC;
      end else if (state != SYNC) begin
         err_n   = 1'b1;
         state_n = SYNC;
      end
      if (tmo) state_n = SYNC;
   end

   // state, strobes and activity registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= SYNC;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         cnt_q     <= '0;
         active    <= 1'b0;
      end else begin
         state     <= state_n;
         valid     <= valid_n;
         frame_err <= err_n;
         cnt_q     <= cnt_n;
         active    <= active_n;
      end
   end

   // digit capture and published field values
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tt_q     <= '0;
         to_q     <= '0;
         mt_q     <= '0;
         seltime  <= '0;
         selmoney <= '0;
      end else begin
         if (ld_tt) tt_q <= dec[3:0];
         if (ld_to) to_q <= dec[3:0];
         if (ld_mt) mt_q <= dec[3:0];
         if (done) begin
            seltime  <= {3'b000, tt_q} * 7'd10
                      + {3'b000, to_q};
            selmoney <= {3'b000, mt_q} * 7'd10
                      + {3'b000, dec[3:0]};
         end
      end
   end

endmodule
